wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the ALU result path (src A) and the load-return path (src L) of the RISC-V core.
- Sits immediately ahead of the write-back mux/regfile write.
- Accepts one source per cycle using valid/ready, applies load-priority with a starvation guard for the ALU, and drives a registered write strobe, destination register and data.
- Suppresses writes to x0.

Parameters:
- WORD_SIZE, 32, data width of each source and of the write port.
- REG_WR_SIZE, 5, destination register index width.
- STARVE_MAX, 3, maximum consecutive load grants while the ALU is waiting before the ALU is forced a grant. Legal range 1..15.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_stall  input  1  back-pressure from the regfile/hazard unit; no grants while high.
- i_alu_valid  input  1  ALU result available.
- i_alu_rd  input  REG_WR_SIZE  ALU destination register.
- i_alu_data  input  WORD_SIZE  ALU result.
- o_alu_ready  output  1  ALU result accepted this cycle.
- i_ld_valid  input  1  load data available.
- i_ld_rd  input  REG_WR_SIZE  load destination register.
- i_ld_data  input  WORD_SIZE  load data.
- o_ld_ready  output  1  load data accepted this cycle.
- o_we  output  1  register-file write enable (registered).
- o_wr_reg  output  REG_WR_SIZE  register-file write address (registered).
- o_data_out  output  WORD_SIZE  register-file write data (registered).
- o_src  output  1  source of the current write: 0 = ALU, 1 = load (registered).

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - o_we=0, o_wr_reg=0, o_data_out=0, o_src=0.
  - starve_cnt=0, state=IDLE.
  - ready outputs are 0 while i_rst is high.
- Handshake:
  - A transfer occurs when valid && ready in the same cycle.
  - Ready outputs are combinational from valids, i_stall and state, and do not depend on the same-cycle ready.
  - A source must hold valid, rd and data stable until accepted.
- Grant rules, evaluated each cycle with i_stall=0:
  - Only ALU valid: grant ALU.
  - Only load valid: grant load.
  - Both valid and starve_cnt < STARVE_MAX: grant load, starve_cnt += 1.
  - Both valid and starve_cnt == STARVE_MAX: grant ALU, starve_cnt cleared.
  - Any ALU grant, or any cycle with ALU not valid: starve_cnt cleared.
  - At most one ready is high per cycle.
- i_stall=1:
  - Both readies are 0.
  - starve_cnt holds.
  - On the next edge o_we=0; o_wr_reg and o_data_out hold.
- Latency: a transfer at edge N appears on o_we/o_wr_reg/o_data_out/o_src after edge N, i.e. valid during cycle N+1. Throughput is one write per cycle.
- x0 rule:
  - An accepted transfer with rd==0 is consumed (ready=1) and counts for arbitration.
  - o_we stays 0 for it; o_wr_reg and o_data_out still update.
- No grant in a cycle: o_we=0 next cycle.
- Ordering: if both sources target the same rd, the later-granted write lands later and wins. No merging is performed.
- State register, reflecting the last cycle's grant, used for o_src and debug:
  - IDLE: no grant or stall.
  - WR_ALU: ALU granted.
  - WR_LD: load granted.
  - Transitions follow the grant decision every cycle. Any state goes to IDLE on i_rst.
- Reset mid-operation:
  - An accepted-but-not-yet-written transfer is discarded (o_we=0 after reset).
  - Sources must re-present their data.

Decomposition:
- Shared package (riscv_pkg): WORD_SIZE, REG_WR_SIZE, the wb state encoding (IDLE=2'd0, WR_ALU=2'd1, WR_LD=2'd2), and source encoding constants SRC_ALU=0, SRC_LD=1.
- One natural sub-module, wb_grant_logic:
  - Combinational grant, plus the starve counter register.
  - Outputs grant_alu and grant_ld.
- The top level holds the output register stage.
- The existing 2:1 mux is reused for data/rd selection into the output register.

Test Plan:
1. Reset, then only ALU valid, rd=5, data=0xDEADBEEF -> o_alu_ready=1 same cycle; next cycle o_we=1, o_wr_reg=5, o_data_out=0xDEADBEEF, o_src=0.
2. Both valid continuously (ALU rd=1 data=0x11, load rd=2 data=0x22, STARVE_MAX=3) -> grant pattern L,L,L,A,L,L,L,A; o_src follows it one cycle later.
3. Load valid, rd=0, data=0xFFFFFFFF -> o_ld_ready=1; next cycle o_we=0, o_wr_reg=0.
4. i_stall=1 for 2 cycles with both valid -> both readies 0 and o_we=0; starve_cnt unchanged; grants resume on the first cycle after i_stall falls.
5. i_rst asserted in the cycle after a load handshake (rd=7) -> o_we=0 on the following edge; all outputs at their reset values.
6. Back-to-back ALU writes, rd=3,4,5 with data 1,2,3 and no load -> o_we=1 for 3 consecutive cycles with matching rd/data, then o_we=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath widths, write-back state encoding and
// write-back source encoding.
package riscv_pkg;

   localparam int WORD_SIZE   = 32;
   localparam int REG_WR_SIZE = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WR_ALU = 2'd1,
      WR_LD  = 2'd2
   } wb_state_t;

   localparam logic SRC_ALU = 1'b0;
   localparam logic SRC_LD  = 1'b1;

endpackage

// File: rtl/mux2.sv
// Generic 2:1 multiplexer used across the datapath.
module mux2 #(
   parameter int WIDTH = 1
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   output logic [WIDTH-1:0] out
);

   assign out = sel ? in1 : in0;

endmodule

// File: rtl/wb_grant_logic.sv
// Write-port grant decision: loads win by default, but the ALU is forced
// through after STARVE_MAX consecutive load grants while it was waiting.
module wb_grant_logic
   import riscv_pkg::*;
#(
   parameter int STARVE_MAX = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic stall,
   input  logic alu_valid,
   input  logic ld_valid,
   output logic grant_alu,
   output logic grant_ld
);

   logic [3:0] starve_cnt_r;
   logic [3:0] starve_cnt_next_s;
   logic       starve_hit_s;

   assign starve_hit_s = (starve_cnt_r >= 4'(STARVE_MAX));

   // Grant selection; nothing is granted during reset or stall.
   always_comb begin
      grant_alu = 1'b0;
      grant_ld  = 1'b0;
      if (rst || stall) begin
         grant_alu = 1'b0;
         grant_ld  = 1'b0;
      end else if (alu_valid && ld_valid) begin
         grant_alu = starve_hit_s;
         grant_ld  = !starve_hit_s;
      end else begin
         grant_alu = alu_valid;
         grant_ld  = ld_valid;
      end
   end

   // Counter only advances when a load wins over a waiting ALU.
   always_comb begin
      starve_cnt_next_s = starve_cnt_r;
      if (stall) begin
         starve_cnt_next_s = starve_cnt_r;
      end else if (!alu_valid || grant_alu) begin
         starve_cnt_next_s = 4'd0;
      end else if (grant_ld) begin
         starve_cnt_next_s = starve_cnt_r + 4'd1;
      end else begin
         starve_cnt_next_s = starve_cnt_r;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_r <= 4'd0;
      end else begin
         starve_cnt_r <= starve_cnt_next_s;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the ALU result path and the load
// return path, with a registered write stage that never writes x0.
module wb_port_arbiter
   import riscv_pkg::*;
#(
   parameter int WORD_SIZE   = riscv_pkg::WORD_SIZE,
   parameter int REG_WR_SIZE = riscv_pkg::REG_WR_SIZE,
   parameter int STARVE_MAX  = 3
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_stall,
   input  logic                   i_alu_valid,
   input  logic [REG_WR_SIZE-1:0] i_alu_rd,
   input  logic [WORD_SIZE-1:0]   i_alu_data,
   output logic                   o_alu_ready,
   input  logic                   i_ld_valid,
   input  logic [REG_WR_SIZE-1:0] i_ld_rd,
   input  logic [WORD_SIZE-1:0]   i_ld_data,
   output logic                   o_ld_ready,
   output logic                   o_we,
   output logic [REG_WR_SIZE-1:0] o_wr_reg,
   output logic [WORD_SIZE-1:0]   o_data_out,
   output logic                   o_src
);

   localparam int PAYLOAD_W = REG_WR_SIZE + WORD_SIZE;

   logic                   grant_alu_s;
   logic                   grant_ld_s;
   logic                   grant_any_s;
   logic [PAYLOAD_W-1:0]   sel_payload_s;
   logic [REG_WR_SIZE-1:0] sel_rd_s;
   logic [WORD_SIZE-1:0]   sel_data_s;
   wb_state_t              state_r;
   wb_state_t              state_next_s;
   logic                   we_r;
   logic [REG_WR_SIZE-1:0] wr_reg_r;
   logic [WORD_SIZE-1:0]   data_r;
   logic                   src_r;

   wb_grant_logic #(
      .STARVE_MAX (STARVE_MAX)
   ) u_grant (
      .clk       (i_clk),
      .rst       (i_rst),
      .stall     (i_stall),
      .alu_valid (i_alu_valid),
      .ld_valid  (i_ld_valid),
      .grant_alu (grant_alu_s),
      .grant_ld  (grant_ld_s)
   );

   mux2 #(
      .WIDTH (PAYLOAD_W)
   ) u_payload_mux (
      .sel (grant_ld_s),
      .in0 ({i_alu_rd, i_alu_data}),
      .in1 ({i_ld_rd, i_ld_data}),
      .out (sel_payload_s)
   );

   assign sel_rd_s    = sel_payload_s[PAYLOAD_W-1:WORD_SIZE];
   assign sel_data_s  = sel_payload_s[WORD_SIZE-1:0];
   assign grant_any_s = grant_alu_s || grant_ld_s;

   assign o_alu_ready = grant_alu_s;
   assign o_ld_ready  = grant_ld_s;

   // Next state tracks this cycle's grant decision.
   always_comb begin
      state_next_s = IDLE;
      case ({grant_ld_s, grant_alu_s})
         2'b01:   state_next_s = WR_ALU;
         2'b10:   state_next_s = WR_LD;
         default: state_next_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Write stage: rd/data update on every grant, strobe is withheld for x0.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         we_r     <= 1'b0;
         wr_reg_r <= '0;
         data_r   <= '0;
         src_r    <= SRC_ALU;
      end else if (grant_any_s) begin
         we_r     <= (sel_rd_s != '0);
         wr_reg_r <= sel_rd_s;
         data_r   <= sel_data_s;
         src_r    <= (state_next_s == WR_LD) ? SRC_LD : SRC_ALU;
      end else begin
         we_r     <= 1'b0;
         src_r    <= SRC_ALU;
      end
   end

   assign o_we       = we_r;
   assign o_wr_reg   = wr_reg_r;
   assign o_data_out = data_r;
   assign o_src      = src_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a
// randomized run, all checked against a behavioural model of the arbitration.
module tb_wb_port_arbiter;

   localparam int SM = 3;

   logic        i_clk = 1'b0;
   logic        i_rst, i_stall;
   logic        i_alu_valid, i_ld_valid;
   logic [4:0]  i_alu_rd, i_ld_rd;
   logic [31:0] i_alu_data, i_ld_data;
   logic        o_alu_ready, o_ld_ready, o_we, o_src;
   logic [4:0]  o_wr_reg;
   logic [31:0] o_data_out;

   int total = 0;
   int bad   = 0;

   // model: consecutive load wins while ALU waits, and the expected write stage
   int          m_cnt;
   logic        m_we, m_src;
   logic [4:0]  m_rd;
   logic [31:0] m_data;

   wb_port_arbiter #(.WORD_SIZE(32), .REG_WR_SIZE(5), .STARVE_MAX(SM)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall),
      .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
      .o_alu_ready(o_alu_ready),
      .i_ld_valid(i_ld_valid), .i_ld_rd(i_ld_rd), .i_ld_data(i_ld_data),
      .o_ld_ready(o_ld_ready),
      .o_we(o_we), .o_wr_reg(o_wr_reg), .o_data_out(o_data_out), .o_src(o_src)
   );

   always #5 i_clk = ~i_clk;

   // 0 = nobody, 1 = ALU, 2 = load
   function automatic int exp_grant();
      if (i_rst || i_stall) return 0;
      if (i_alu_valid && i_ld_valid) return (m_cnt < SM) ? 2 : 1;
      if (i_alu_valid) return 1;
      if (i_ld_valid) return 2;
      return 0;
   endfunction

   task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
      i_alu_valid = av; i_alu_rd = ard; i_alu_data = ad;
      i_ld_valid  = lv; i_ld_rd  = lrd; i_ld_data  = ld;
   endtask

   // advance one clock and update the model from the inputs seen at that edge
   task automatic tick();
      int g;
      g = exp_grant();
      @(posedge i_clk);
      if (i_rst) begin
         m_cnt = 0; m_we = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_src = 1'b0;
      end else begin
         if (!i_stall) begin
            if (!i_alu_valid || g == 1) m_cnt = 0;
            else if (g == 2) m_cnt = m_cnt + 1;
         end
         if (g == 1) begin
            m_we = (i_alu_rd != 5'd0); m_rd = i_alu_rd; m_data = i_alu_data; m_src = 1'b0;
         end else if (g == 2) begin
            m_we = (i_ld_rd != 5'd0); m_rd = i_ld_rd; m_data = i_ld_data; m_src = 1'b1;
         end else begin
            m_we = 1'b0; m_src = 1'b0;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_stall = 1'b0;
      set_in(1'b1, 5'd9, 32'h1234_5678, 1'b1, 5'd10, 32'h9ABC_DEF0);
      #3;
      total++;
      if ({o_alu_ready, o_ld_ready} !== 2'b00) begin
         bad++; $display("FAIL reset_ready got=%b want=00", {o_alu_ready, o_ld_ready});
      end
      tick(); tick();
      total++;
      if ({o_we, o_wr_reg, o_data_out, o_src} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
         bad++; $display("FAIL reset_out got we=%b rd=%0d d=%h src=%b want all zero",
                         o_we, o_wr_reg, o_data_out, o_src);
      end
      i_rst = 1'b0;
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
   endtask

   task automatic test_alu_only();
      set_in(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
      #3;
      total++;
      if ({o_alu_ready, o_ld_ready} !== 2'b10) begin
         bad++; $display("FAIL alu_only_ready got=%b want=10", {o_alu_ready, o_ld_ready});
      end
      tick();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      total++;
      if ({o_we, o_wr_reg, o_data_out, o_src} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0}) begin
         bad++; $display("FAIL alu_only_out got we=%b rd=%0d d=%h src=%b want 1/5/deadbeef/0",
                         o_we, o_wr_reg, o_data_out, o_src);
      end
      tick();
   endtask

   task automatic test_starvation();
      logic [7:0] pat;
      pat = 8'b0111_0111;  // bit i = 1 when load wins cycle i
      set_in(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
      for (int i = 0; i < 8; i++) begin
         #2;
         total++;
         if ({o_alu_ready, o_ld_ready} !== {~pat[i], pat[i]}) begin
            bad++; $display("FAIL starve_ready cyc=%0d got=%b want=%b", i,
                            {o_alu_ready, o_ld_ready}, {~pat[i], pat[i]});
         end
         tick();
         total++;
         if ({o_we, o_wr_reg, o_data_out, o_src} !==
             {1'b1, pat[i] ? 5'd2 : 5'd1, pat[i] ? 32'h22 : 32'h11, pat[i]}) begin
            bad++; $display("FAIL starve_out cyc=%0d got rd=%0d d=%h src=%b want src=%b",
                            i, o_wr_reg, o_data_out, o_src, pat[i]);
         end
      end
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
   endtask

   task automatic test_x0();
      set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
      #3;
      total++;
      if ({o_alu_ready, o_ld_ready} !== 2'b01) begin
         bad++; $display("FAIL x0_ready got=%b want=01", {o_alu_ready, o_ld_ready});
      end
      tick();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      total++;
      if ({o_we, o_wr_reg, o_data_out} !== {1'b0, 5'd0, 32'hFFFF_FFFF}) begin
         bad++; $display("FAIL x0_out got we=%b rd=%0d d=%h want 0/0/ffffffff",
                         o_we, o_wr_reg, o_data_out);
      end
      tick();
   endtask

   task automatic test_stall();
      // two load wins first so the counter is mid-way when the stall hits
      set_in(1'b1, 5'd6, 32'hA6, 1'b1, 5'd8, 32'hB8);
      tick(); tick();
      i_stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #2;
         total++;
         if ({o_alu_ready, o_ld_ready} !== 2'b00) begin
            bad++; $display("FAIL stall_ready cyc=%0d got=%b want=00", i, {o_alu_ready, o_ld_ready});
         end
         tick();
         total++;
         if ({o_we, o_wr_reg, o_data_out} !== {1'b0, 5'd8, 32'hB8}) begin
            bad++; $display("FAIL stall_out cyc=%0d got we=%b rd=%0d d=%h want 0/8/b8",
                            i, o_we, o_wr_reg, o_data_out);
         end
      end
      i_stall = 1'b0;
      // third load win, then the ALU must be forced through
      for (int i = 0; i < 2; i++) begin
         #2;
         total++;
         if ({o_alu_ready, o_ld_ready} !== ((i == 0) ? 2'b01 : 2'b10)) begin
            bad++; $display("FAIL stall_resume cyc=%0d got=%b want=%b", i,
                            {o_alu_ready, o_ld_ready}, (i == 0) ? 2'b01 : 2'b10);
         end
         tick();
      end
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
   endtask

   task automatic test_reset_mid();
      set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_7777);
      tick();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      i_rst = 1'b1;
      total++;
      if ({o_we, o_wr_reg} !== {1'b1, 5'd7}) begin
         bad++; $display("FAIL rstmid_pre got we=%b rd=%0d want 1/7", o_we, o_wr_reg);
      end
      tick();
      i_rst = 1'b0;
      total++;
      if ({o_we, o_wr_reg, o_data_out, o_src} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
         bad++; $display("FAIL rstmid_post got we=%b rd=%0d d=%h src=%b want all zero",
                         o_we, o_wr_reg, o_data_out, o_src);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         if (i < 3) set_in(1'b1, 5'(3 + i), 32'(1 + i), 1'b0, 5'd0, 32'd0);
         else       set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
         tick();
         total++;
         if (i < 3 && {o_we, o_wr_reg, o_data_out} !== {1'b1, 5'(3 + i), 32'(1 + i)}) begin
            bad++; $display("FAIL b2b cyc=%0d got we=%b rd=%0d d=%0d want 1/%0d/%0d",
                            i, o_we, o_wr_reg, o_data_out, 3 + i, 1 + i);
         end else if (i == 3 && o_we !== 1'b0) begin
            bad++; $display("FAIL b2b_end got we=%b want 0", o_we);
         end
      end
   endtask

   task automatic test_random();
      int g;
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      for (int i = 0; i < 400; i++) begin
         if (!i_alu_valid && ($urandom_range(0, 3) != 0)) begin
            i_alu_valid = 1'b1; i_alu_rd = 5'($urandom_range(0, 31)); i_alu_data = $urandom;
         end
         if (!i_ld_valid && ($urandom_range(0, 3) != 0)) begin
            i_ld_valid = 1'b1; i_ld_rd = 5'($urandom_range(0, 31)); i_ld_data = $urandom;
         end
         i_stall = ($urandom_range(0, 5) == 0);
         i_rst   = ($urandom_range(0, 60) == 0);
         #2;
         g = exp_grant();
         total++;
         if ({o_alu_ready, o_ld_ready} !== {g == 1, g == 2}) begin
            bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", i,
                            {o_alu_ready, o_ld_ready}, {g == 1, g == 2});
         end
         tick();
         total++;
         if ({o_we, o_wr_reg, o_data_out, o_src} !== {m_we, m_rd, m_data, m_src}) begin
            bad++; $display("FAIL rand_out cyc=%0d got we=%b rd=%0d d=%h src=%b want we=%b rd=%0d d=%h src=%b",
                            i, o_we, o_wr_reg, o_data_out, o_src, m_we, m_rd, m_data, m_src);
         end
         if (g == 1) i_alu_valid = 1'b0;
         if (g == 2) i_ld_valid = 1'b0;
      end
      i_rst = 1'b0; i_stall = 1'b0;
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
   endtask

   initial begin
      m_cnt = 0; m_we = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_src = 1'b0;
      #1;
      test_reset();
      test_alu_only();
      test_starvation();
      test_x0();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
